// File: rtl/spi_pkg.sv
// Shared SPI types: FSM state encoding, CPOL/CPHA mode pair, counter width helpers.
package spi_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    XFER,
    HOLD
  } spi_state_t;

  // Clock polarity/phase pair, identical in meaning on master and slave side.
  typedef struct packed {
    logic cpol;
    logic cpha;
  } spi_mode_t;

  localparam spi_mode_t SPI_MODE0 = '{cpol: 1'b0, cpha: 1'b0};
  localparam spi_mode_t SPI_MODE1 = '{cpol: 1'b0, cpha: 1'b1};
  localparam spi_mode_t SPI_MODE2 = '{cpol: 1'b1, cpha: 1'b0};
  localparam spi_mode_t SPI_MODE3 = '{cpol: 1'b1, cpha: 1'b1};

  // Half-period counter must hold 0..CLK_DIV.
  function automatic int hcnt_w(input int clk_div);
    return $clog2(clk_div + 1);
  endfunction

  // Toggle counter must hold 0..2*DATA_WIDTH without wrapping.
  function automatic int bcnt_w(input int data_width);
    return $clog2(2 * data_width + 1);
  endfunction

endpackage

// File: rtl/spi_sclk_gen.sv
// SCLK generator: half-period counter, SCLK register and edge strobes.
// tick marks the clk edge that ends a half-period; the strobes mark the
// same edge when it also toggles SCLK, so the owner can act in lockstep.
module spi_sclk_gen
  import spi_pkg::*;
#(
  parameter bit CPOL    = 1'b0,
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,         // transfer in progress (SETUP..HOLD)
  input  logic toggle_en,   // SCLK may toggle on this half-period boundary
  output logic tick,
  output logic lead_strobe,
  output logic trail_strobe,
  output logic sclk
);

  localparam int HW = hcnt_w(CLK_DIV);

  logic [HW-1:0] half_cnt;

  assign tick         = run && (half_cnt == HW'(CLK_DIV - 1));
  // SCLK still at its idle level means the coming toggle is a leading edge.
  assign lead_strobe  = tick && toggle_en && (sclk == CPOL);
  assign trail_strobe = tick && toggle_en && (sclk != CPOL);

  // Count clk cycles within a half-period; restart at every boundary.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      half_cnt <= '0;
    end else if (!run || tick) begin
      half_cnt <= '0;
    end else begin
      half_cnt <= half_cnt + 1'b1;
    end
  end

  // Toggle SCLK on each strobe, park it at the idle level otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk <= CPOL;
    end else if (lead_strobe || trail_strobe) begin
      sclk <= ~sclk;
    end else if (!toggle_en) begin
      sclk <= CPOL;
    end
  end

endmodule

// File: rtl/spi_master_tx.sv
// SPI master: one MSB-first word per CS_n assertion, full duplex.
// The FSM, shift registers and toggle counter live here; SCLK timing comes
// from spi_sclk_gen. The first SCLK toggle fires on the SETUP->XFER edge,
// which is why the generator may toggle during SETUP as well as XFER.
module spi_master_tx
  import spi_pkg::*;
#(
  parameter bit CPOL       = 1'b0,
  parameter bit CPHA       = 1'b0,
  parameter int DATA_WIDTH = 8,
  parameter int CLK_DIV    = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  output logic                  busy,
  output logic                  sclk,
  output logic                  mosi,
  input  logic                  miso,
  output logic                  cs_n
);

  localparam spi_mode_t MODE = '{cpol: CPOL, cpha: CPHA};
  localparam int        BW   = bcnt_w(DATA_WIDTH);

  spi_state_t            state;
  logic [DATA_WIDTH-1:0] tx_shift;
  logic [DATA_WIDTH-1:0] rx_shift;
  logic [BW-1:0]         bit_cnt;
  logic                  tick;
  logic                  lead_strobe;
  logic                  trail_strobe;
  logic                  last_toggle;
  logic                  sample_edge;
  logic                  shift_edge;

  spi_sclk_gen #(
    .CPOL    (MODE.cpol),
    .CLK_DIV (CLK_DIV)
  ) u_sclk_gen (
    .clk          (clk),
    .rst_n        (rst_n),
    .run          (state != IDLE),
    .toggle_en    ((state == SETUP) || (state == XFER)),
    .tick         (tick),
    .lead_strobe  (lead_strobe),
    .trail_strobe (trail_strobe),
    .sclk         (sclk)
  );

  assign tx_ready    = (state == IDLE);
  assign last_toggle = (bit_cnt == BW'(2 * DATA_WIDTH - 1));
  assign sample_edge = MODE.cpha ? trail_strobe : lead_strobe;
  // In CPHA=0 the MSB is already on mosi from accept, so the final trailing
  // edge has nothing left to drive.
  assign shift_edge  = MODE.cpha ? lead_strobe : (trail_strobe && !last_toggle);

  // Transfer FSM with registered pins, shift registers and toggle counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cs_n     <= 1'b1;
      busy     <= 1'b0;
      mosi     <= 1'b0;
      rx_valid <= 1'b0;
      rx_data  <= '0;
      tx_shift <= '0;
      rx_shift <= '0;
      bit_cnt  <= '0;
    end else begin
      rx_valid <= 1'b0;
      if (sample_edge) begin
        rx_shift <= {rx_shift[DATA_WIDTH-2:0], miso};
      end
      if (shift_edge) begin
        mosi     <= tx_shift[DATA_WIDTH-1];
        tx_shift <= tx_shift << 1;
      end
      if (lead_strobe || trail_strobe) begin
        bit_cnt <= bit_cnt + 1'b1;
      end
      case (state)
        IDLE: begin
          if (tx_valid) begin
            state    <= SETUP;
            cs_n     <= 1'b0;
            busy     <= 1'b1;
            bit_cnt  <= '0;
            rx_shift <= '0;
            if (MODE.cpha) begin
              tx_shift <= tx_data;
            end else begin
              tx_shift <= tx_data << 1;
              mosi     <= tx_data[DATA_WIDTH-1];
            end
          end
        end
        SETUP: begin
          if (tick) state <= XFER;
        end
        XFER: begin
          if (tick && last_toggle) state <= HOLD;
        end
        HOLD: begin
          if (tick) begin
            state    <= IDLE;
            cs_n     <= 1'b1;
            busy     <= 1'b0;
            rx_data  <= rx_shift;
            rx_valid <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master_tx.sv
// Bench for spi_master_tx: five instances covering all four SPI modes and
// the smallest legal size. Each transfer's pin waveform is captured cycle by
// cycle and compared against a model computed from the timing rules.
module tb_spi_master_tx;

  localparam int NI = 5;
  localparam bit P_CPOL [NI] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
  localparam bit P_CPHA [NI] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
  localparam int P_DW   [NI] = '{8, 8, 2, 5, 3};
  localparam int P_CD   [NI] = '{2, 2, 1, 3, 1};

  typedef struct packed {
    logic       cs_n;
    logic       sclk;
    logic       mosi;
    logic       busy;
    logic       tx_ready;
    logic       rx_valid;
    logic [7:0] rx_data;
  } obs_t;

  logic       clk = 1'b0;
  logic       rst_n_a    [NI];
  logic       tx_valid_a [NI];
  logic [7:0] tx_data_a  [NI];
  logic       tx_ready_a [NI];
  logic [7:0] rx_data_a  [NI];
  logic       rx_valid_a [NI];
  logic       busy_a     [NI];
  logic       sclk_a     [NI];
  logic       mosi_a     [NI];
  logic       miso_a     [NI];
  logic       cs_n_a     [NI];
  logic       loop_a     [NI];
  logic [7:0] slave_word [NI];
  logic       prev_mosi  [NI];
  logic [7:0] prev_rx    [NI];

  obs_t cap [0:255];
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < NI; gi++) begin : g_dut
    logic [P_DW[gi]-1:0] txd_w;
    logic [P_DW[gi]-1:0] rxd_w;
    logic sl_bit  = 1'b0;
    logic sl_prev = P_CPOL[gi];
    int   sl_idx  = 0;

    assign txd_w         = tx_data_a[gi][P_DW[gi]-1:0];
    assign rx_data_a[gi] = 8'(rxd_w);
    assign miso_a[gi]    = loop_a[gi] ? mosi_a[gi] : sl_bit;

    spi_master_tx #(
      .CPOL       (P_CPOL[gi]),
      .CPHA       (P_CPHA[gi]),
      .DATA_WIDTH (P_DW[gi]),
      .CLK_DIV    (P_CD[gi])
    ) u_dut (
      .clk      (clk),
      .rst_n    (rst_n_a[gi]),
      .tx_data  (txd_w),
      .tx_valid (tx_valid_a[gi]),
      .tx_ready (tx_ready_a[gi]),
      .rx_data  (rxd_w),
      .rx_valid (rx_valid_a[gi]),
      .busy     (busy_a[gi]),
      .sclk     (sclk_a[gi]),
      .mosi     (mosi_a[gi]),
      .miso     (miso_a[gi]),
      .cs_n     (cs_n_a[gi])
    );

    // Behavioural SPI slave returning slave_word MSB first in the same mode.
    always @(negedge clk) begin
      if (cs_n_a[gi]) begin
        sl_idx = P_DW[gi] - 1;
        sl_bit = P_CPHA[gi] ? 1'b0 : slave_word[gi][P_DW[gi]-1];
      end else if (sclk_a[gi] != sl_prev) begin
        if ((sl_prev == P_CPOL[gi]) == P_CPHA[gi]) begin
          if (P_CPHA[gi]) begin
            if (sl_idx >= 0) sl_bit = slave_word[gi][sl_idx];
            sl_idx--;
          end else begin
            sl_idx--;
            if (sl_idx >= 0) sl_bit = slave_word[gi][sl_idx];
          end
        end
      end
      sl_prev = sclk_a[gi];
    end
  end

  function automatic int tend_of(input int u);
    return 1 + (2 * P_DW[u] + 1) * P_CD[u];
  endfunction

  function automatic obs_t observe(input int u);
    obs_t o;
    o.cs_n     = cs_n_a[u];
    o.sclk     = sclk_a[u];
    o.mosi     = mosi_a[u];
    o.busy     = busy_a[u];
    o.tx_ready = tx_ready_a[u];
    o.rx_valid = rx_valid_a[u];
    o.rx_data  = rx_data_a[u];
    return o;
  endfunction

  function automatic obs_t reset_exp(input int u);
    obs_t e;
    e          = '0;
    e.cs_n     = 1'b1;
    e.sclk     = P_CPOL[u];
    e.tx_ready = 1'b1;
    return e;
  endfunction

  // Expected pins in cycle c after accept (accept edge = 0), from the rules:
  // toggle k at cycle 1+k*CLK_DIV, end of transfer at 1+(2W+1)*CLK_DIV.
  function automatic obs_t model(input int u, input int c, input logic [7:0] tx,
                                 input logic [7:0] rxw, input logic pm,
                                 input logic [7:0] prx);
    obs_t e;
    int   dw, cd, te, k, n;
    dw = P_DW[u];
    cd = P_CD[u];
    te = tend_of(u);
    k  = (c - 1) / cd;
    if (k > 2 * dw) k = 2 * dw;
    e            = '0;
    e.cs_n       = (c >= te);
    e.busy       = (c < te);
    e.tx_ready   = (c >= te);
    e.rx_valid   = (c == te);
    e.sclk       = P_CPOL[u] ^ (k % 2 == 1);
    e.rx_data    = (c >= te) ? rxw : prx;
    if (!P_CPHA[u]) begin
      n      = ((k > 2 * dw - 1) ? 2 * dw - 1 : k) / 2;
      e.mosi = tx[dw-1-n];
    end else begin
      n      = (k + 1) / 2;
      e.mosi = (n == 0) ? pm : tx[dw-n];
    end
    return e;
  endfunction

  task automatic start(input int u, input logic [7:0] tx);
    @(negedge clk);
    tx_data_a[u]  = tx;
    tx_valid_a[u] = 1'b1;
    @(posedge clk);
  endtask

  // Record n cycles of pins. mode 0: idle inputs; 1: hold tx_valid with
  // data2 through the rx_valid cycle; 2: random tx_valid/tx_data while busy.
  task automatic capture(input int u, input int n, input int mode, input logic [7:0] data2);
    for (int c = 1; c <= n; c++) begin
      @(negedge clk);
      cap[c] = observe(u);
      case (mode)
        1: begin
          tx_valid_a[u] = (c <= tend_of(u));
          tx_data_a[u]  = data2;
        end
        2: begin
          tx_valid_a[u] = (c < tend_of(u)) ? 1'($urandom_range(0, 1)) : 1'b0;
          tx_data_a[u]  = 8'($urandom);
        end
        default: tx_valid_a[u] = 1'b0;
      endcase
    end
  endtask

  task automatic test_reset();
    obs_t e;
    for (int u = 0; u < NI; u++) begin
      rst_n_a[u] = 1'b0; tx_valid_a[u] = 1'b0; tx_data_a[u] = 8'h00;
      loop_a[u] = 1'b1; slave_word[u] = 8'h00; prev_mosi[u] = 1'b0; prev_rx[u] = 8'h00;
    end
    repeat (2) @(negedge clk);
    for (int u = 0; u < NI; u++) begin
      e = reset_exp(u); tests++;
      if (observe(u) !== e) begin
        fails++;
        $display("FAIL reset u%0d: got %b want %b", u, observe(u), e);
      end
      rst_n_a[u] = 1'b1;
    end
  endtask

  task automatic test_mode0();
    obs_t e;
    loop_a[0] = 1'b1;
    start(0, 8'hA5);
    capture(0, tend_of(0) + 1, 0, 8'h00);
    for (int c = 1; c <= tend_of(0) + 1; c++) begin
      e = model(0, c, 8'hA5, 8'hA5, prev_mosi[0], prev_rx[0]); tests++;
      if (cap[c] !== e) begin
        fails++;
        $display("FAIL mode0 cycle %0d: got %b want %b", c, cap[c], e);
      end
    end
    prev_mosi[0] = 1'b1; prev_rx[0] = 8'hA5;
    $display("[TB] mode0 tx=a5 rx=%h", rx_data_a[0]);
  endtask

  task automatic test_mode3();
    obs_t e;
    loop_a[1] = 1'b0; slave_word[1] = 8'hC3;
    start(1, 8'h3C);
    capture(1, tend_of(1) + 1, 0, 8'h00);
    for (int c = 1; c <= tend_of(1) + 1; c++) begin
      e = model(1, c, 8'h3C, 8'hC3, prev_mosi[1], prev_rx[1]); tests++;
      if (cap[c] !== e) begin
        fails++;
        $display("FAIL mode3 cycle %0d: got %b want %b", c, cap[c], e);
      end
    end
    prev_mosi[1] = 1'b0; prev_rx[1] = 8'hC3;
    $display("[TB] mode3 tx=3c rx=%h", rx_data_a[1]);
  endtask

  task automatic test_back_to_back();
    obs_t e;
    int   te;
    te = tend_of(0);
    loop_a[0] = 1'b1;
    start(0, 8'h01);
    capture(0, 2 * te + 1, 1, 8'h80);
    for (int c = 1; c <= 2 * te + 1; c++) begin
      if (c <= te) e = model(0, c, 8'h01, 8'h01, prev_mosi[0], prev_rx[0]);
      else         e = model(0, c - te, 8'h80, 8'h80, 1'b1, 8'h01);
      tests++;
      if (cap[c] !== e) begin
        fails++;
        $display("FAIL back_to_back cycle %0d: got %b want %b", c, cap[c], e);
      end
    end
    prev_mosi[0] = 1'b0; prev_rx[0] = 8'h80;
    $display("[TB] back_to_back tx=01,80 rx=%h", rx_data_a[0]);
  endtask

  task automatic test_busy_ignore();
    obs_t       e;
    logic [7:0] tx;
    tx = 8'($urandom);
    loop_a[0] = 1'b1;
    start(0, tx);
    capture(0, tend_of(0) + 1, 2, 8'h00);
    for (int c = 1; c <= tend_of(0) + 1; c++) begin
      e = model(0, c, tx, tx, prev_mosi[0], prev_rx[0]); tests++;
      if (cap[c] !== e) begin
        fails++;
        $display("FAIL busy_ignore cycle %0d: got %b want %b", c, cap[c], e);
      end
    end
    prev_mosi[0] = tx[0]; prev_rx[0] = tx;
    $display("[TB] busy_ignore tx=%h rx=%h", tx, rx_data_a[0]);
  endtask

  task automatic test_reset_mid();
    obs_t e;
    loop_a[0] = 1'b1;
    start(0, 8'hC6);
    capture(0, 11, 0, 8'h00);
    for (int c = 1; c <= 11; c++) begin
      e = model(0, c, 8'hC6, 8'hC6, prev_mosi[0], prev_rx[0]); tests++;
      if (cap[c] !== e) begin
        fails++;
        $display("FAIL reset_mid pre cycle %0d: got %b want %b", c, cap[c], e);
      end
    end
    @(negedge clk);
    #2 rst_n_a[0] = 1'b0;
    #1;
    e = reset_exp(0); tests++;
    if (observe(0) !== e) begin
      fails++;
      $display("FAIL reset_mid async: got %b want %b", observe(0), e);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      tests++;
      if (observe(0) !== e) begin
        fails++;
        $display("FAIL reset_mid hold %0d: got %b want %b", i, observe(0), e);
      end
    end
    rst_n_a[0] = 1'b1;
    prev_mosi[0] = 1'b0; prev_rx[0] = 8'h00;
    start(0, 8'h5A);
    capture(0, tend_of(0) + 1, 0, 8'h00);
    for (int c = 1; c <= tend_of(0) + 1; c++) begin
      e = model(0, c, 8'h5A, 8'h5A, prev_mosi[0], prev_rx[0]); tests++;
      if (cap[c] !== e) begin
        fails++;
        $display("FAIL reset_mid post cycle %0d: got %b want %b", c, cap[c], e);
      end
    end
    prev_mosi[0] = 1'b0; prev_rx[0] = 8'h5A;
    $display("[TB] reset_mid tx=5a rx=%h", rx_data_a[0]);
  endtask

  task automatic test_min_size();
    obs_t e;
    loop_a[2] = 1'b1;
    start(2, 8'h02);
    capture(2, tend_of(2) + 1, 0, 8'h00);
    for (int c = 1; c <= tend_of(2) + 1; c++) begin
      e = model(2, c, 8'h02, 8'h02, prev_mosi[2], prev_rx[2]); tests++;
      if (cap[c] !== e) begin
        fails++;
        $display("FAIL min_size cycle %0d: got %b want %b", c, cap[c], e);
      end
    end
    prev_mosi[2] = 1'b0; prev_rx[2] = 8'h02;
    $display("[TB] min_size tx=2 rx=%h", rx_data_a[2]);
  endtask

  task automatic test_random();
    obs_t       e;
    logic [7:0] mask, tx, rxw;
    int         u, md;
    for (int it = 0; it < 24; it++) begin
      u             = $urandom_range(0, NI - 1);
      mask          = 8'((1 << P_DW[u]) - 1);
      tx            = 8'($urandom) & mask;
      slave_word[u] = 8'($urandom) & mask;
      loop_a[u]     = 1'($urandom_range(0, 1));
      rxw           = loop_a[u] ? tx : slave_word[u];
      md            = $urandom_range(0, 1) * 2;
      start(u, tx);
      capture(u, tend_of(u) + 1, md, 8'h00);
      for (int c = 1; c <= tend_of(u) + 1; c++) begin
        e = model(u, c, tx, rxw, prev_mosi[u], prev_rx[u]); tests++;
        if (cap[c] !== e) begin
          fails++;
          $display("FAIL random it%0d u%0d cycle %0d: got %b want %b", it, u, c, cap[c], e);
        end
      end
      prev_mosi[u] = tx[0]; prev_rx[u] = rxw;
      $display("[TB] random u=%0d tx=%h rx=%h want %h", u, tx, rx_data_a[u], rxw);
    end
  endtask

  initial begin
    test_reset();
    test_mode0();
    test_mode3();
    test_back_to_back();
    test_busy_ignore();
    test_reset_mid();
    test_min_size();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", tests, fails);
    $fatal(1, "watchdog expired");
  end

endmodule
